// File: rtl/fifo_drop_guard.sv
// Overload guard in front of sram_fifo: FWFT buffer that discards arbiter words
// while the downstream FIFO is near-full, then inserts one loss-count marker.
module fifo_drop_guard #(
  parameter int          DEPTH_LOG2 = 3,
  parameter logic [7:0]  MARKER_HDR = 8'hF0
) (
  input  logic        BUS_CLK,
  input  logic        BUS_RST_N,
  input  logic        DROP_EN,
  input  logic        FIFO_NEAR_FULL,
  input  logic        IN_WRITE,
  input  logic [31:0] IN_DATA,
  output logic        IN_READY,
  output logic [31:0] OUT_DATA,
  output logic        OUT_EMPTY,
  input  logic        OUT_READ_NEXT,
  output logic        DROPPING,
  output logic [31:0] TOTAL_DROP
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {PASS, DROP, MARK} state_t;

  state_t                  state, state_n;
  logic [PW-1:0]           wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic                    full_q, empty_q;
  logic [DEPTH-1:0][31:0]  mem;
  logic [31:0]             out_data_q;
  logic [23:0]             drop_cnt, drop_cnt_n;
  logic [31:0]             total_drop, total_drop_n;
  logic                    wr_en, rd_en;
  logic [31:0]             wr_data;

  // Ready depends only on registered state, never on OUT_READ_NEXT.
  assign IN_READY   = BUS_RST_N & ((state == PASS) ? !full_q : (state == DROP));
  assign OUT_DATA   = out_data_q;
  assign OUT_EMPTY  = empty_q;
  assign DROPPING   = (state == DROP);
  assign TOTAL_DROP = total_drop;
  assign rd_en      = OUT_READ_NEXT & !empty_q;

  always_comb begin
    state_n      = state;
    wr_en        = 1'b0;
    wr_data      = IN_DATA;
    drop_cnt_n   = drop_cnt;
    total_drop_n = total_drop;
    case (state)
      PASS: begin
        wr_en = IN_WRITE & !full_q;
        if (DROP_EN & FIFO_NEAR_FULL) state_n = DROP;
      end
      DROP: begin
        if (IN_WRITE) begin
          if (drop_cnt != 24'hFFFFFF)     drop_cnt_n   = drop_cnt + 24'd1;
          if (total_drop != 32'hFFFFFFFF) total_drop_n = total_drop + 32'd1;
        end
        // Losing DROP_EN asks to leave just like the overload ending does.
        if ((!FIFO_NEAR_FULL | !DROP_EN) & !full_q)
          state_n = (drop_cnt_n != 24'd0) ? MARK : PASS;
      end
      MARK: begin
        if (!full_q) begin
          wr_en      = 1'b1;
          wr_data    = {MARKER_HDR, drop_cnt};
          drop_cnt_n = 24'd0;
          state_n    = PASS;
        end
      end
      default: state_n = PASS;
    endcase
    wr_ptr_n = wr_ptr + {{DEPTH_LOG2{1'b0}}, wr_en};
    rd_ptr_n = rd_ptr + {{DEPTH_LOG2{1'b0}}, rd_en};
  end

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST_N && wr_en) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
  end

  always_ff @(posedge BUS_CLK) begin
    if (!BUS_RST_N) begin
      state      <= PASS;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      out_data_q <= '0;
      drop_cnt   <= '0;
      total_drop <= '0;
    end else begin
      state      <= state_n;
      wr_ptr     <= wr_ptr_n;
      rd_ptr     <= rd_ptr_n;
      full_q     <= (wr_ptr_n[DEPTH_LOG2] != rd_ptr_n[DEPTH_LOG2]) &&
                    (wr_ptr_n[DEPTH_LOG2-1:0] == rd_ptr_n[DEPTH_LOG2-1:0]);
      // Output side sees writes one edge late: the head register needs the RAM word settled.
      empty_q    <= (wr_ptr == rd_ptr_n);
      if (wr_ptr != rd_ptr_n) out_data_q <= mem[rd_ptr_n[DEPTH_LOG2-1:0]];
      drop_cnt   <= drop_cnt_n;
      total_drop <= total_drop_n;
    end
  end

endmodule

// File: tb/tb_fifo_drop_guard.sv
// Directed bench for fifo_drop_guard: pass-through, backpressure, drop/marker,
// saturation, no-drop exit and mid-drop reset.
module tb_fifo_drop_guard;

  logic        BUS_CLK = 1'b0;
  logic        BUS_RST_N, DROP_EN, FIFO_NEAR_FULL, IN_WRITE, OUT_READ_NEXT;
  logic [31:0] IN_DATA;
  logic        IN_READY, OUT_EMPTY, DROPPING;
  logic [31:0] OUT_DATA, TOTAL_DROP;

  int n_chk = 0;
  int n_err = 0;
  int acc;
  logic [31:0] rx[$];

  fifo_drop_guard dut (
    .BUS_CLK(BUS_CLK), .BUS_RST_N(BUS_RST_N), .DROP_EN(DROP_EN),
    .FIFO_NEAR_FULL(FIFO_NEAR_FULL), .IN_WRITE(IN_WRITE), .IN_DATA(IN_DATA),
    .IN_READY(IN_READY), .OUT_DATA(OUT_DATA), .OUT_EMPTY(OUT_EMPTY),
    .OUT_READ_NEXT(OUT_READ_NEXT), .DROPPING(DROPPING), .TOTAL_DROP(TOTAL_DROP)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  // Words consumed downstream, sampled mid-cycle ahead of the consuming edge.
  always @(negedge BUS_CLK)
    if (BUS_RST_N && OUT_READ_NEXT && !OUT_EMPTY) rx.push_back(OUT_DATA);

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge BUS_CLK);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    BUS_RST_N = 1'b0; DROP_EN = 1'b1; FIFO_NEAR_FULL = 1'b0;
    IN_WRITE = 1'b0; IN_DATA = '0; OUT_READ_NEXT = 1'b0;
    tick(2);
    chk("rst_ready", {31'd0, IN_READY}, 32'd0);
    chk("rst_empty", {31'd0, OUT_EMPTY}, 32'd1);
    chk("rst_data", OUT_DATA, 32'd0);
    chk("rst_dropping", {31'd0, DROPPING}, 32'd0);
    chk("rst_total", TOTAL_DROP, 32'd0);
    BUS_RST_N = 1'b1;
    #1;
    chk("rel_ready", {31'd0, IN_READY}, 32'd1);

    // Pass-through: 20 back-to-back words with reads always on
    rx.delete();
    OUT_READ_NEXT = 1'b1; IN_WRITE = 1'b1; IN_DATA = 32'd0;
    tick();
    chk("lat_still_empty", {31'd0, OUT_EMPTY}, 32'd1);
    IN_DATA = 32'd1;
    tick();
    chk("lat_visible", {31'd0, OUT_EMPTY}, 32'd0);
    chk("lat_data", OUT_DATA, 32'd0);
    for (int i = 2; i < 20; i++) begin
      IN_DATA = i;
      tick();
    end
    IN_WRITE = 1'b0;
    tick(4);
    chk("pt_count", rx.size(), 32'd20);
    for (int i = 0; i < 20; i++)
      chk($sformatf("pt_word%0d", i), (i < rx.size()) ? rx[i] : 32'hDEADBEEF, i);
    chk("pt_total", TOTAL_DROP, 32'd0);
    chk("pt_empty", {31'd0, OUT_EMPTY}, 32'd1);

    // Backpressure: DROP_EN low, no reads
    rx.delete();
    DROP_EN = 1'b0; OUT_READ_NEXT = 1'b0; IN_WRITE = 1'b1; IN_DATA = 32'hA0;
    acc = 0;
    for (int k = 0; k < 12; k++) begin
      if (IN_READY) begin
        acc++;
        tick();
        IN_DATA++;
      end else tick();
    end
    chk("bp_accepted", acc, 32'd8);
    chk("bp_ready_low", {31'd0, IN_READY}, 32'd0);
    OUT_READ_NEXT = 1'b1;
    tick();
    OUT_READ_NEXT = 1'b0;
    chk("bp_ready_after_read", {31'd0, IN_READY}, 32'd1);
    tick();
    chk("bp_ready_refull", {31'd0, IN_READY}, 32'd0);
    IN_WRITE = 1'b0; OUT_READ_NEXT = 1'b1;
    tick(12);
    chk("bp_count", rx.size(), 32'd9);
    for (int i = 0; i < 9; i++)
      chk($sformatf("bp_word%0d", i), (i < rx.size()) ? rx[i] : 32'hDEADBEEF, 32'hA0 + i);

    // Drop window of 5 words, then marker
    rx.delete();
    DROP_EN = 1'b1;
    IN_WRITE = 1'b1; IN_DATA = 32'hB0; tick();
    IN_DATA = 32'hB1; tick();
    IN_WRITE = 1'b0; FIFO_NEAR_FULL = 1'b1;
    tick();
    chk("dr_enter", {31'd0, DROPPING}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      IN_WRITE = 1'b1; IN_DATA = 32'hC0 + k;
      chk($sformatf("dr_ready%0d", k), {31'd0, IN_READY}, 32'd1);
      tick();
      chk($sformatf("dr_dropping%0d", k), {31'd0, DROPPING}, 32'd1);
    end
    IN_WRITE = 1'b0; FIFO_NEAR_FULL = 1'b0;
    tick();
    chk("dr_exit", {31'd0, DROPPING}, 32'd0);
    chk("mk_ready", {31'd0, IN_READY}, 32'd0);
    tick();
    chk("mk_back_pass", {31'd0, IN_READY}, 32'd1);
    IN_WRITE = 1'b1; IN_DATA = 32'hD0; tick();
    IN_DATA = 32'hD1; tick();
    IN_WRITE = 1'b0;
    tick(5);
    chk("dr_count", rx.size(), 32'd5);
    if (rx.size() == 5) begin
      chk("dr_w0", rx[0], 32'hB0);
      chk("dr_w1", rx[1], 32'hB1);
      chk("dr_marker", rx[2], 32'hF0000005);
      chk("dr_w3", rx[3], 32'hD0);
      chk("dr_w4", rx[4], 32'hD1);
    end
    chk("dr_total", TOTAL_DROP, 32'd5);

    // Marker held back while the buffer is full
    rx.delete();
    OUT_READ_NEXT = 1'b0; IN_WRITE = 1'b1;
    for (int k = 0; k < 8; k++) begin
      IN_DATA = 32'hE0 + k;
      tick();
    end
    IN_WRITE = 1'b0;
    chk("mh_full", {31'd0, IN_READY}, 32'd0);
    FIFO_NEAR_FULL = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      IN_WRITE = 1'b1; IN_DATA = 32'h60 + k;
      tick();
    end
    IN_WRITE = 1'b0; FIFO_NEAR_FULL = 1'b0;
    tick(3);
    chk("mh_head", OUT_DATA, 32'hE0);
    chk("mh_not_empty", {31'd0, OUT_EMPTY}, 32'd0);
    chk("mh_total", TOTAL_DROP, 32'd8);
    OUT_READ_NEXT = 1'b1;
    tick();
    OUT_READ_NEXT = 1'b0;
    tick(3);
    OUT_READ_NEXT = 1'b1;
    tick(12);
    chk("mh_count", rx.size(), 32'd9);
    for (int i = 0; i < 8; i++)
      chk($sformatf("mh_word%0d", i), (i < rx.size()) ? rx[i] : 32'hDEADBEEF, 32'hE0 + i);
    chk("mh_marker", (rx.size() > 8) ? rx[8] : 32'hDEADBEEF, 32'hF0000003);
    chk("mh_dropping", {31'd0, DROPPING}, 32'd0);

    // Saturating drop counter
    rx.delete();
    FIFO_NEAR_FULL = 1'b1;
    tick();
    IN_WRITE = 1'b1;
    force dut.drop_cnt = 24'hFFFFFE;
    tick();
    release dut.drop_cnt;
    tick(2);
    IN_WRITE = 1'b0; FIFO_NEAR_FULL = 1'b0;
    tick(6);
    chk("sat_count", rx.size(), 32'd1);
    chk("sat_marker", (rx.size() > 0) ? rx[0] : 32'hDEADBEEF, 32'hF0FFFFFF);
    chk("sat_total", TOTAL_DROP, 32'd11);

    // Near-full pulse with nothing written: no marker
    rx.delete();
    FIFO_NEAR_FULL = 1'b1;
    tick();
    chk("nd_enter", {31'd0, DROPPING}, 32'd1);
    FIFO_NEAR_FULL = 1'b0;
    tick();
    chk("nd_exit", {31'd0, DROPPING}, 32'd0);
    chk("nd_pass_ready", {31'd0, IN_READY}, 32'd1);
    tick(3);
    chk("nd_no_marker", rx.size(), 32'd0);

    // Reset in the middle of a drop window with 4 words buffered
    rx.delete();
    OUT_READ_NEXT = 1'b0; IN_WRITE = 1'b1;
    for (int k = 0; k < 4; k++) begin
      IN_DATA = 32'h70 + k;
      tick();
    end
    IN_WRITE = 1'b0; FIFO_NEAR_FULL = 1'b1;
    tick();
    IN_WRITE = 1'b1;
    tick(2);
    chk("rs_pre_total", TOTAL_DROP, 32'd13);
    IN_WRITE = 1'b0; FIFO_NEAR_FULL = 1'b0; BUS_RST_N = 1'b0;
    tick();
    chk("rs_ready", {31'd0, IN_READY}, 32'd0);
    chk("rs_empty", {31'd0, OUT_EMPTY}, 32'd1);
    chk("rs_total", TOTAL_DROP, 32'd0);
    chk("rs_dropping", {31'd0, DROPPING}, 32'd0);
    chk("rs_data", OUT_DATA, 32'd0);
    BUS_RST_N = 1'b1;
    #1;
    chk("rs_rel_ready", {31'd0, IN_READY}, 32'd1);
    tick();
    OUT_READ_NEXT = 1'b1;
    tick(5);
    chk("rs_no_marker", rx.size(), 32'd0);
    chk("rs_still_empty", {31'd0, OUT_EMPTY}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
